gerenciador_ativos: RTL and testbench

- Active-node table for the path-search engine, directly downstream of localizador_vizinhos_validos.
- Absorbs its atualizar (insert/relax) and desativar (remove) pulses and drives the ocupado back-pressure those commands obey.
- Answers buscar requests from the approval stage: returns the active node with the smallest estimate, distancia + menor_vizinho.
- Sequential scan, one table entry per clock; table held in registers.

---
 rtl/ga_pkg.sv | 41 ++++
 rtl/ga_comparador_menor.sv | 44 ++++
 rtl/gerenciador_ativos.sv | 235 +++++++++++++++++++++++
 tb/tb_gerenciador_ativos.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ga_pkg : shared states, entry layout and estimate key for gerenciador_ativos
// Revision: 1.0
// ---------------------------------------------------------------------------
package ga_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE        = 3'd0,
    ST_BUSCA_ADDR  = 3'd1,
    ST_ESCREVER    = 3'd2,
    ST_BUSCA_MENOR = 3'd3,
    ST_RESULTADO   = 3'd4
  } ga_estado_e;

  // Sliced down to ADDR_WIDTH by the user; all-ones means "no node".
  localparam logic [31:0] ENDERECO_NULO = '1;

  // Entry layout, LSB first: endereco | distancia | anterior | menor_vizinho
  localparam int OFS_ENDERECO = 0;

  function automatic int ofs_distancia(input int aw);
    return aw;
  endfunction

  function automatic int ofs_anterior(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int ofs_custo(input int aw, input int dw);
    return 2 * aw + dw;
  endfunction

  function automatic logic [31:0] chave_estimativa(input logic [31:0] d, input logic [31:0] h);
    return d + h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ga_comparador_menor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ga_comparador_menor : registered running minimum (key, index, found flag)
// Revision: 1.0
// ---------------------------------------------------------------------------
module ga_comparador_menor #(
  parameter int KEY_WIDTH = 7,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio_i,
  input  logic                 amostrar_i,
  input  logic [KEY_WIDTH-1:0] chave_i,
  input  logic [IDX_WIDTH-1:0] indice_i,
  output logic                 achado_o,
  output logic [IDX_WIDTH-1:0] indice_o
);

  logic                 achado_q;
  logic [KEY_WIDTH-1:0] chave_q;
  logic [IDX_WIDTH-1:0] indice_q;
  logic                 w_menor;

  // Strict compare keeps the earliest index on ties.
  assign w_menor = amostrar_i && (!achado_q || (chave_i < chave_q));

  always_ff @(posedge clk) begin
    if (rst || inicio_i) begin
      achado_q <= 1'b0;
      chave_q  <= '0;
      indice_q <= '0;
    end else if (w_menor) begin
      achado_q <= 1'b1;
      chave_q  <= chave_i;
      indice_q <= indice_i;
    end
  end

  assign achado_o = achado_q;
  assign indice_o = indice_q;

endmodule
`default_nettype wire

// File: rtl/gerenciador_ativos.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gerenciador_ativos : active-node table with insert/relax, remove, min search
// Revision: 1.0
// ---------------------------------------------------------------------------
module gerenciador_ativos
  import ga_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int CUSTO_WIDTH     = 4,
  parameter int MAX_ATIVOS      = 16,
  parameter int IDX_WIDTH       = $clog2(MAX_ATIVOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lvv_atualizar_in,
  input  logic [ADDR_WIDTH-1:0]      lvv_endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0] lvv_distancia_in,
  input  logic [ADDR_WIDTH-1:0]      lvv_anterior_in,
  input  logic [CUSTO_WIDTH-1:0]     lvv_menor_vizinho_in,
  input  logic                       lvv_desativar_in,
  input  logic [ADDR_WIDTH-1:0]      lvv_desativar_addr_in,
  input  logic                       aap_buscar_in,
  output logic                       ga_ocupado_out,
  output logic                       ga_resultado_valido_out,
  output logic                       ga_vazio_out,
  output logic [ADDR_WIDTH-1:0]      ga_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0] ga_distancia_out,
  output logic [ADDR_WIDTH-1:0]      ga_anterior_out,
  output logic                       ga_descartado_out,
  output logic [IDX_WIDTH:0]         ga_num_ativos_out
);

  localparam int ENTRY_WIDTH = 2 * ADDR_WIDTH + DISTANCIA_WIDTH + CUSTO_WIDTH;
  localparam int C_OFS_END   = OFS_ENDERECO;
  localparam int C_OFS_DIST  = ofs_distancia(ADDR_WIDTH);
  localparam int C_OFS_ANT   = ofs_anterior(ADDR_WIDTH, DISTANCIA_WIDTH);
  localparam int C_OFS_CUSTO = ofs_custo(ADDR_WIDTH, DISTANCIA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] C_NULO   = ADDR_WIDTH'(ENDERECO_NULO);
  localparam logic [IDX_WIDTH-1:0]  C_ULTIMO = IDX_WIDTH'(MAX_ATIVOS - 1);

  ga_estado_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]       idx_q, idx_d;
  logic                       op_remover_q, op_remover_d;
  logic [ADDR_WIDTH-1:0]      cmd_end_q, cmd_end_d;
  logic [ADDR_WIDTH-1:0]      cmd_ant_q, cmd_ant_d;
  logic [DISTANCIA_WIDTH-1:0] cmd_dist_q, cmd_dist_d;
  logic [CUSTO_WIDTH-1:0]     cmd_custo_q, cmd_custo_d;
  logic                       achou_q, achou_d;
  logic [IDX_WIDTH-1:0]       achou_idx_q, achou_idx_d;
  logic                       livre_q, livre_d;
  logic [IDX_WIDTH-1:0]       livre_idx_q, livre_idx_d;

  logic [MAX_ATIVOS-1:0]      valido_q;
  logic [ENTRY_WIDTH-1:0]     entrada_q [MAX_ATIVOS];
  logic [IDX_WIDTH:0]         num_q;

  logic [ADDR_WIDTH-1:0]      res_end_q;
  logic [DISTANCIA_WIDTH-1:0] res_dist_q;
  logic [ADDR_WIDTH-1:0]      res_ant_q;

  logic [ADDR_WIDTH-1:0]      w_cur_end;
  logic [DISTANCIA_WIDTH-1:0] w_cur_dist;
  logic [CUSTO_WIDTH-1:0]     w_cur_custo;
  logic [DISTANCIA_WIDTH:0]   w_chave;
  logic [DISTANCIA_WIDTH-1:0] w_achou_dist;
  logic                       w_cmp_inicio, w_cmp_amostrar, w_cmp_achado;
  logic [IDX_WIDTH-1:0]       w_cmp_idx;
  logic                       w_remover, w_relaxar, w_inserir, w_descartar;
  logic [ADDR_WIDTH-1:0]      w_res_end, w_res_ant;
  logic [DISTANCIA_WIDTH-1:0] w_res_dist;
  logic [ENTRY_WIDTH-1:0]     w_nova_entrada;

  assign w_cur_end    = entrada_q[idx_q][C_OFS_END +: ADDR_WIDTH];
  assign w_cur_dist   = entrada_q[idx_q][C_OFS_DIST +: DISTANCIA_WIDTH];
  assign w_cur_custo  = entrada_q[idx_q][C_OFS_CUSTO +: CUSTO_WIDTH];
  assign w_chave      = (DISTANCIA_WIDTH+1)'(chave_estimativa(32'(w_cur_dist), 32'(w_cur_custo)));
  assign w_achou_dist = entrada_q[achou_idx_q][C_OFS_DIST +: DISTANCIA_WIDTH];
  assign w_nova_entrada = {cmd_custo_q, cmd_ant_q, cmd_dist_q, cmd_end_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      op_remover_q <= 1'b0;
      cmd_end_q    <= '0;
      cmd_ant_q    <= '0;
      cmd_dist_q   <= '0;
      cmd_custo_q  <= '0;
      achou_q      <= 1'b0;
      achou_idx_q  <= '0;
      livre_q      <= 1'b0;
      livre_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_remover_q <= op_remover_d;
      cmd_end_q    <= cmd_end_d;
      cmd_ant_q    <= cmd_ant_d;
      cmd_dist_q   <= cmd_dist_d;
      cmd_custo_q  <= cmd_custo_d;
      achou_q      <= achou_d;
      achou_idx_q  <= achou_idx_d;
      livre_q      <= livre_d;
      livre_idx_q  <= livre_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_remover_d = op_remover_q;
    cmd_end_d    = cmd_end_q;
    cmd_ant_d    = cmd_ant_q;
    cmd_dist_d   = cmd_dist_q;
    cmd_custo_d  = cmd_custo_q;
    achou_d      = achou_q;
    achou_idx_d  = achou_idx_q;
    livre_d      = livre_q;
    livre_idx_d  = livre_idx_q;
    w_cmp_inicio = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A command naming the null node counts as absent for priority.
        if (lvv_desativar_in && (lvv_desativar_addr_in != C_NULO)) begin
          op_remover_d = 1'b1;
          cmd_end_d    = lvv_desativar_addr_in;
          achou_d      = 1'b0;
          livre_d      = 1'b0;
          idx_d        = '0;
          state_d      = ST_BUSCA_ADDR;
        end else if (lvv_atualizar_in && (lvv_endereco_in != C_NULO)) begin
          op_remover_d = 1'b0;
          cmd_end_d    = lvv_endereco_in;
          cmd_ant_d    = lvv_anterior_in;
          cmd_dist_d   = lvv_distancia_in;
          cmd_custo_d  = lvv_menor_vizinho_in;
          achou_d      = 1'b0;
          livre_d      = 1'b0;
          idx_d        = '0;
          state_d      = ST_BUSCA_ADDR;
        end else if (aap_buscar_in) begin
          w_cmp_inicio = 1'b1;
          idx_d        = '0;
          state_d      = ST_BUSCA_MENOR;
        end
      end
      ST_BUSCA_ADDR: begin
        if (valido_q[idx_q] && (w_cur_end == cmd_end_q) && !achou_q) begin
          achou_d     = 1'b1;
          achou_idx_d = idx_q;
        end
        if (!valido_q[idx_q] && !livre_q) begin
          livre_d     = 1'b1;
          livre_idx_d = idx_q;
        end
        if (idx_q == C_ULTIMO) state_d = ST_ESCREVER;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_ESCREVER: state_d = ST_IDLE;
      ST_BUSCA_MENOR: begin
        if (idx_q == C_ULTIMO) state_d = ST_RESULTADO;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_RESULTADO: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign w_cmp_amostrar = (state_q == ST_BUSCA_MENOR) && valido_q[idx_q];

  ga_comparador_menor #(
    .KEY_WIDTH (DISTANCIA_WIDTH + 1),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_comparador (
    .clk        (clk),
    .rst        (rst),
    .inicio_i   (w_cmp_inicio),
    .amostrar_i (w_cmp_amostrar),
    .chave_i    (w_chave),
    .indice_i   (idx_q),
    .achado_o   (w_cmp_achado),
    .indice_o   (w_cmp_idx)
  );

  assign w_remover   = (state_q == ST_ESCREVER) &&  op_remover_q && achou_q;
  assign w_relaxar   = (state_q == ST_ESCREVER) && !op_remover_q && achou_q && (cmd_dist_q < w_achou_dist);
  assign w_inserir   = (state_q == ST_ESCREVER) && !op_remover_q && !achou_q && livre_q;
  assign w_descartar = (state_q == ST_ESCREVER) && !op_remover_q && !achou_q && !livre_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valido_q <= '0;
      num_q    <= '0;
    end else if (w_remover) begin
      valido_q[achou_idx_q] <= 1'b0;
      num_q                 <= num_q - 1'b1;
    end else if (w_inserir) begin
      valido_q[livre_idx_q]  <= 1'b1;
      entrada_q[livre_idx_q] <= w_nova_entrada;
      num_q                  <= num_q + 1'b1;
    end else if (w_relaxar) begin
      entrada_q[achou_idx_q] <= w_nova_entrada;
    end
  end

  assign w_res_end  = w_cmp_achado ? entrada_q[w_cmp_idx][C_OFS_END +: ADDR_WIDTH] : C_NULO;
  assign w_res_dist = w_cmp_achado ? entrada_q[w_cmp_idx][C_OFS_DIST +: DISTANCIA_WIDTH] : '0;
  assign w_res_ant  = w_cmp_achado ? entrada_q[w_cmp_idx][C_OFS_ANT +: ADDR_WIDTH] : '0;

  // Result fields are live during the strobe and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_end_q  <= '0;
      res_dist_q <= '0;
      res_ant_q  <= '0;
    end else if (state_q == ST_RESULTADO) begin
      res_end_q  <= w_res_end;
      res_dist_q <= w_res_dist;
      res_ant_q  <= w_res_ant;
    end
  end

  assign ga_ocupado_out          = (state_q != ST_IDLE);
  assign ga_resultado_valido_out = (state_q == ST_RESULTADO);
  assign ga_vazio_out            = (state_q == ST_RESULTADO) && !w_cmp_achado;
  assign ga_endereco_out         = (state_q == ST_RESULTADO) ? w_res_end  : res_end_q;
  assign ga_distancia_out        = (state_q == ST_RESULTADO) ? w_res_dist : res_dist_q;
  assign ga_anterior_out         = (state_q == ST_RESULTADO) ? w_res_ant  : res_ant_q;
  assign ga_descartado_out       = w_descartar;
  assign ga_num_ativos_out       = num_q;

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_ativos.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gerenciador_ativos : directed self-checking bench for gerenciador_ativos
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gerenciador_ativos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       atu = 1'b0, des = 1'b0, bus = 1'b0;
  logic [9:0] end_in = '0, ant_in = '0, des_addr = '0;
  logic [5:0] dist_in = '0;
  logic [3:0] h_in = '0;

  logic       ocupado, valido, vazio, descartado;
  logic [9:0] end_out, ant_out;
  logic [5:0] dist_out;
  logic [4:0] num;

  int checks = 0;
  int errors = 0;

  int         lat, ocup, ndesc;
  logic [9:0] r_end, r_ant;
  logic [5:0] r_dist;
  logic       r_vazio;

  always #5 clk = ~clk;

  gerenciador_ativos dut (
    .clk                     (clk),
    .rst                     (rst),
    .lvv_atualizar_in        (atu),
    .lvv_endereco_in         (end_in),
    .lvv_distancia_in        (dist_in),
    .lvv_anterior_in         (ant_in),
    .lvv_menor_vizinho_in    (h_in),
    .lvv_desativar_in        (des),
    .lvv_desativar_addr_in   (des_addr),
    .aap_buscar_in           (bus),
    .ga_ocupado_out          (ocupado),
    .ga_resultado_valido_out (valido),
    .ga_vazio_out            (vazio),
    .ga_endereco_out         (end_out),
    .ga_distancia_out        (dist_out),
    .ga_anterior_out         (ant_out),
    .ga_descartado_out       (descartado),
    .ga_num_ativos_out       (num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle command pulse; returns at the negedge after the acceptance edge.
  task automatic pulso(input logic d, input logic a, input logic b, input logic [9:0] da,
                       input logic [9:0] ea, input logic [5:0] di, input logic [9:0] an,
                       input logic [3:0] h);
    @(negedge clk);
    des = d; atu = a; bus = b; des_addr = da;
    end_in = ea; dist_in = di; ant_in = an; h_in = h;
    @(negedge clk);
    des = 1'b0; atu = 1'b0; bus = 1'b0;
  endtask

  task automatic esperar_livre();
    ocup = 0; ndesc = 0;
    while (ocupado && ocup < 100) begin
      ocup++;
      if (descartado) ndesc++;
      @(negedge clk);
    end
    if (ocup >= 100) chk("timeout_ocupado", 32'(ocup), 32'd0);
  endtask

  task automatic atualizar(input logic [9:0] a, input logic [5:0] d, input logic [9:0] an, input logic [3:0] h);
    pulso(1'b0, 1'b1, 1'b0, 10'd0, a, d, an, h);
    esperar_livre();
  endtask

  task automatic desativar(input logic [9:0] a);
    pulso(1'b1, 1'b0, 1'b0, a, 10'd0, 6'd0, 10'd0, 4'd0);
    esperar_livre();
  endtask

  task automatic buscar();
    pulso(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 6'd0, 10'd0, 4'd0);
    lat = 1;
    while (!valido && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("timeout_busca", 32'(lat), 32'd17);
    r_end = end_out; r_dist = dist_out; r_ant = ant_out; r_vazio = vazio;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_valido", 32'(valido), 32'd0);
    chk("rst_endereco", 32'(end_out), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_descartado", 32'(descartado), 32'd0);
    rst = 1'b0;

    buscar();
    chk("vazio_latencia", 32'(lat), 32'd17);
    chk("vazio_flag", 32'(r_vazio), 32'd1);
    chk("vazio_endereco", 32'(r_end), 32'h3FF);
    chk("vazio_dist", 32'(r_dist), 32'd0);
    chk("vazio_num", 32'(num), 32'd0);

    atualizar(10'd5, 6'd10, 10'd1, 4'd2);
    chk("ins_ocupado_ciclos", 32'(ocup), 32'd17);
    atualizar(10'd9, 6'd4, 10'd1, 4'd3);
    atualizar(10'd7, 6'd6, 10'd2, 4'd1);
    buscar();
    chk("tres_num", 32'(num), 32'd3);
    chk("tres_vazio", 32'(r_vazio), 32'd0);
    chk("tres_endereco", 32'(r_end), 32'd9);
    chk("tres_dist", 32'(r_dist), 32'd4);
    chk("tres_ant", 32'(r_ant), 32'd1);
    chk("hold_valido", 32'(valido), 32'd0);
    chk("hold_endereco", 32'(end_out), 32'd9);

    atualizar(10'd5, 6'd12, 10'd3, 4'd2);
    buscar();
    chk("relax_maior_end", 32'(r_end), 32'd9);
    chk("relax_maior_num", 32'(num), 32'd3);
    atualizar(10'd5, 6'd3, 10'd8, 4'd2);
    buscar();
    chk("relax_end", 32'(r_end), 32'd5);
    chk("relax_dist", 32'(r_dist), 32'd3);
    chk("relax_ant", 32'(r_ant), 32'd8);

    desativar(10'd9);
    chk("rem_num", 32'(num), 32'd2);
    desativar(10'd42);
    chk("rem_ausente_num", 32'(num), 32'd2);
    buscar();
    chk("rem_busca_end", 32'(r_end), 32'd5);

    for (int i = 0; i < 14; i++) atualizar(10'(200 + i), 6'd20, 10'd0, 4'd5);
    chk("cheia_num", 32'(num), 32'd16);
    atualizar(10'd100, 6'd1, 10'd0, 4'd0);
    chk("descartado_pulsos", 32'(ndesc), 32'd1);
    chk("descartado_num", 32'(num), 32'd16);
    buscar();
    chk("cheia_busca_end", 32'(r_end), 32'd5);

    atualizar(10'd7, 6'd1, 10'd4, 4'd1);
    buscar();
    chk("cheia_relax_end", 32'(r_end), 32'd7);
    chk("cheia_relax_dist", 32'(r_dist), 32'd1);
    chk("cheia_relax_ant", 32'(r_ant), 32'd4);

    pulso(1'b1, 1'b1, 1'b0, 10'd7, 10'd300, 6'd0, 10'd0, 4'd0);
    esperar_livre();
    chk("prio_num", 32'(num), 32'd15);
    desativar(10'd300);
    chk("prio_sem_insercao", 32'(num), 32'd15);
    buscar();
    chk("prio_busca_end", 32'(r_end), 32'd5);

    pulso(1'b0, 1'b1, 1'b0, 10'd0, 10'd301, 6'd9, 10'd0, 4'd0);
    pulso(1'b0, 1'b1, 1'b0, 10'd0, 10'd302, 6'd9, 10'd0, 4'd0);
    esperar_livre();
    chk("ocupado_num", 32'(num), 32'd16);
    desativar(10'd302);
    chk("ocupado_descartado", 32'(num), 32'd16);
    desativar(10'd301);
    chk("ocupado_rem_301", 32'(num), 32'd15);

    pulso(1'b0, 1'b1, 1'b0, 10'd0, 10'h3FF, 6'd1, 10'd0, 4'd0);
    chk("nulo_ocupado", 32'(ocupado), 32'd0);
    chk("nulo_num", 32'(num), 32'd15);

    pulso(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 6'd0, 10'd0, 4'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_meio_ocupado", 32'(ocupado), 32'd0);
    chk("rst_meio_valido", 32'(valido), 32'd0);
    chk("rst_meio_endereco", 32'(end_out), 32'd0);
    chk("rst_meio_num", 32'(num), 32'd0);
    buscar();
    chk("rst_meio_vazio", 32'(r_vazio), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
